// File: rtl/loopback_pkg.sv
// Shared widths and scaling helper for the ADC -> filter -> DAC loopback path.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package loopback_pkg;

    localparam int ADC_W         = 12;
    localparam int DAC_W         = 14;
    localparam int MAX_LOG2_TAPS = 4;

    // Left shift that moves an ADC-width value into DAC code width.
    function automatic int scale_shift(input int out_w, input int in_w);
        return out_w - in_w;
    endfunction

endpackage

// File: rtl/sample_history.sv
// Circular history of the last 2^LOG2_TAPS samples; exposes the entry about to be overwritten.
// Latency: combinational read of the oldest entry, write takes effect on the next edge.
// Backpressure: none internally; the caller only asserts wr_en on an accepted sample.
module sample_history
    import loopback_pkg::*;
#(
    parameter int IN_W      = ADC_W,
    parameter int LOG2_TAPS = 2
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [IN_W-1:0] wr_dat,
    output logic [IN_W-1:0] oldest_dat
);

    localparam int TAPS  = 1 << LOG2_TAPS;
    // A single-tap window still needs a 1-bit pointer; it simply never leaves 0.
    localparam int PTR_W = (LOG2_TAPS > 0) ? LOG2_TAPS : 1;

    logic [IN_W-1:0]  hist [TAPS];
    logic [PTR_W-1:0] wptr;

    // The slot at wptr holds the sample leaving the window on the next write.
    assign oldest_dat = hist[wptr];

    // Overwrite the oldest slot and advance the pointer, wrapping at TAPS.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
        end else if (wr_en) begin
            hist[wptr] <= wr_dat;
            wptr       <= (wptr == PTR_W'(TAPS - 1)) ? '0 : wptr + 1'b1;
        end
    end

endmodule

// File: rtl/adc_avg_filter.sv
// Boxcar moving average of 2^LOG2_TAPS ADC samples, scaled into DAC code width (FILTER_BYPASS_EN adds a bypass port).
// Latency: 1 cycle from accept to m_axis_tvalid, full throughput of one sample per cycle.
// Backpressure: single output register; s_axis_tready = !m_axis_tvalid || m_axis_tready, tdata held while stalled.
module adc_avg_filter
    import loopback_pkg::*;
#(
    parameter int IN_W      = ADC_W,
    parameter int OUT_W     = DAC_W,
    parameter int LOG2_TAPS = 2
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
`ifdef FILTER_BYPASS_EN
    input  logic             bypass,
`endif
    output logic             fill_done
);

    localparam int TAPS   = 1 << LOG2_TAPS;
    localparam int SUM_W  = IN_W + LOG2_TAPS;
    localparam int SHIFT  = scale_shift(OUT_W, IN_W);
    localparam int WIDE_W = SUM_W + SHIFT;
    localparam int FC_W   = LOG2_TAPS + 1;

    logic              accept;
    logic [IN_W-1:0]   oldest;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;
    logic [WIDE_W-1:0] sum_wide;
    logic [OUT_W-1:0]  filt_dat;
    logic [OUT_W-1:0]  out_dat;
    logic [FC_W-1:0]   fill_cnt;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    sample_history #(
        .IN_W      (IN_W),
        .LOG2_TAPS (LOG2_TAPS)
    ) u_history (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (accept),
        .wr_dat     (s_axis_tdata),
        .oldest_dat (oldest)
    );

    // Running sum: add the new sample, drop the one leaving the window.
    // SUM_W is wide enough for TAPS full-scale samples, so this never wraps.
    assign sum_next = sum + SUM_W'(s_axis_tdata) - SUM_W'(oldest);

    // Widen to DAC scale first, then divide by TAPS, so no fractional bits are lost early.
    assign sum_wide = WIDE_W'(sum_next) << SHIFT;
    assign filt_dat = OUT_W'(sum_wide >> LOG2_TAPS);

`ifdef FILTER_BYPASS_EN
    // Bypass only changes what is presented; the window keeps tracking so filtering resumes cleanly.
    assign out_dat = bypass ? (OUT_W'(s_axis_tdata) << SHIFT) : filt_dat;
`else
    assign out_dat = filt_dat;
`endif

    // Running sum register, advanced only on accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum_next;
        end
    end

    // Count accepts up to TAPS; fill_done latches once the window holds only real samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt  <= '0;
            fill_done <= 1'b0;
        end else if (accept && (fill_cnt != FC_W'(TAPS))) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == FC_W'(TAPS - 1)) begin
                fill_done <= 1'b1;
            end
        end
    end

    // Output register: load on accept, otherwise drain when the DAC takes the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= out_dat;
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_avg_filter.sv
// Self-checking bench for adc_avg_filter at default parameters (12 -> 14 bits, 4 taps).
// Expected words come from a window-sum reference model queued at drive time and popped at output.
// Fixed spec vectors are also compared against the sequence of words the DAC side consumed.
module tb_adc_avg_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [13:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        fill_done;
`ifdef FILTER_BYPASS_EN
    logic        bypass = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [13:0] exp_q[$];
    logic [13:0] obs_q[$];
    int          win[$];
    logic        mdl_vld = 1'b0;
    int          acc_cnt = 0;

    always #5 clk = ~clk;

    adc_avg_filter dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef FILTER_BYPASS_EN
        .bypass        (bypass),
`endif
        .fill_done     (fill_done)
    );

    // One clock of stimulus: drive at negedge, check outputs, then advance the model to match the next posedge.
    task automatic cycle(input logic v, input logic [11:0] x, input logic r, input logic byp);
        logic        acc;
        int          s;
        logic [13:0] e;
        @(negedge clk);
        s_axis_tvalid = v;
        s_axis_tdata  = x;
        m_axis_tready = r;
`ifdef FILTER_BYPASS_EN
        bypass = byp;
`endif
        #1;
        checks++;
        if (m_axis_tvalid !== mdl_vld) begin
            errors++;
            $display("FAIL m_tvalid: got %b expected %b", m_axis_tvalid, mdl_vld);
        end
        checks++;
        if (s_axis_tready !== (!mdl_vld || r)) begin
            errors++;
            $display("FAIL s_tready: got %b expected %b", s_axis_tready, (!mdl_vld || r));
        end
        checks++;
        if (fill_done !== (acc_cnt >= 4)) begin
            errors++;
            $display("FAIL fill_done: got %b expected %b (accepts=%0d)", fill_done, (acc_cnt >= 4), acc_cnt);
        end
        if (mdl_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: output valid with got %h but expected queue empty", m_axis_tdata);
            end else begin
                if (m_axis_tdata !== exp_q[0]) begin
                    errors++;
                    $display("FAIL m_tdata: got %h expected %h", m_axis_tdata, exp_q[0]);
                end
                if (r) begin
                    obs_q.push_back(m_axis_tdata);
                    void'(exp_q.pop_front());
                end
            end
        end
        acc = v && (!mdl_vld || r);
        if (acc) begin
            win.push_back(int'(x));
            if (win.size() > 4) void'(win.pop_front());
            s = 0;
            foreach (win[i]) s += win[i];
            e = byp ? {x, 2'b00} : 14'(s);
            exp_q.push_back(e);
            acc_cnt++;
            mdl_vld = 1'b1;
        end else if (mdl_vld && r) begin
            mdl_vld = 1'b0;
        end
    endtask

    task automatic drain;
        repeat (3) cycle(1'b0, 12'h000, 1'b1, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending words expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        win.delete();
        mdl_vld = 1'b0;
        acc_cnt = 0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 14'h0 || fill_done !== 1'b0 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got vld=%b dat=%h fill=%b rdy=%b expected 0 0000 0 1",
                     m_axis_tvalid, m_axis_tdata, fill_done, s_axis_tready);
        end
    endtask

    task automatic test_reset;
        do_reset();
    endtask

    task automatic test_ramp;
        logic [13:0] tbl[6];
        tbl = '{14'h0800, 14'h1000, 14'h1800, 14'h2000, 14'h2000, 14'h2000};
        do_reset();
        obs_q.delete();
        for (int i = 0; i < 6; i++) cycle(1'b1, 12'h800, 1'b1, 1'b0);
        drain();
        checks++;
        if (obs_q.size() != 6) begin
            errors++;
            $display("FAIL ramp_count: got %0d expected 6", obs_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs_q[i] !== tbl[i]) begin
                    errors++;
                    $display("FAIL ramp[%0d]: got %h expected %h", i, obs_q[i], tbl[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        // Window still holds four 0x800 samples from the ramp.
        obs_q.delete();
        cycle(1'b1, 12'h100, 1'b1, 1'b0);
        repeat (5) cycle(1'b1, 12'h200, 1'b0, 1'b0);
        cycle(1'b1, 12'h200, 1'b1, 1'b0);
        drain();
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== 14'h1900 || obs_q[1] !== 14'h1300) begin
            errors++;
            $display("FAIL backpressure: got %0d words first %h expected 2 words 1900 1300",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 14'h0);
        end
    endtask

    task automatic test_full_scale;
        logic [13:0] tbl[8];
        tbl = '{14'h0FFF, 14'h1FFE, 14'h2FFD, 14'h3FFC, 14'h2FFD, 14'h1FFE, 14'h0FFF, 14'h0000};
        do_reset();
        obs_q.delete();
        for (int i = 0; i < 8; i++) cycle(1'b1, (i < 4) ? 12'hFFF : 12'h000, 1'b1, 1'b0);
        drain();
        checks++;
        if (obs_q.size() != 8) begin
            errors++;
            $display("FAIL full_scale_count: got %0d expected 8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_q[i] !== tbl[i]) begin
                    errors++;
                    $display("FAIL full_scale[%0d]: got %h expected %h", i, obs_q[i], tbl[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        obs_q.delete();
        for (int i = 0; i < 20; i++) cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b1, 1'b0);
        cycle(1'b0, 12'h000, 1'b1, 1'b0);
        checks++;
        if (obs_q.size() != 20) begin
            errors++;
            $display("FAIL back_to_back: got %0d words expected 20", obs_q.size());
        end
        drain();
    endtask

    task automatic test_reset_midstream;
        obs_q.delete();
        cycle(1'b1, 12'h300, 1'b1, 1'b0);
        cycle(1'b1, 12'h300, 1'b1, 1'b0);
        do_reset();
        cycle(1'b1, 12'h800, 1'b1, 1'b0);
        drain();
        checks++;
        if (obs_q.size() != 2 || obs_q[1] !== 14'h0800) begin
            errors++;
            $display("FAIL reset_midstream: got %0d words last %h expected 2 words last 0800",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 14'h0);
        end
    endtask

`ifdef FILTER_BYPASS_EN
    task automatic test_bypass;
        do_reset();
        repeat (4) cycle(1'b1, 12'h800, 1'b1, 1'b0);
        obs_q.delete();
        cycle(1'b1, 12'h100, 1'b1, 1'b1);
        cycle(1'b1, 12'h100, 1'b1, 1'b0);
        drain();
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== 14'h0400 || obs_q[1] !== 14'h1200) begin
            errors++;
            $display("FAIL bypass: got %0d words first %h expected 2 words 0400 1200",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 14'h0);
        end
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_ramp();
        test_backpressure();
        test_full_scale();
        test_back_to_back();
        test_reset_midstream();
`ifdef FILTER_BYPASS_EN
        test_bypass();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
